// File: rtl/mc_dp_pkg.sv
// Shared definitions for the multi-cycle datapath: opcodes, ALU function codes,
// instruction field positions, FSM state encoding and flag bit indices.
package mc_dp_pkg;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_ST   = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [2:0] OP_ALUI = 3'b100;
  localparam logic [2:0] OP_ILL  = 3'b101;
  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  localparam logic [3:0] FS_MOVA  = 4'h0;
  localparam logic [3:0] FS_INC   = 4'h1;
  localparam logic [3:0] FS_ADD   = 4'h2;
  localparam logic [3:0] FS_ADDC  = 4'h3;
  localparam logic [3:0] FS_SUBB  = 4'h4;
  localparam logic [3:0] FS_SUB   = 4'h5;
  localparam logic [3:0] FS_DEC   = 4'h6;
  localparam logic [3:0] FS_MOVA2 = 4'h7;
  localparam logic [3:0] FS_AND   = 4'h8;
  localparam logic [3:0] FS_OR    = 4'h9;
  localparam logic [3:0] FS_XOR   = 4'hA;
  localparam logic [3:0] FS_NOT   = 4'hB;
  localparam logic [3:0] FS_MOVB  = 4'hC;
  localparam logic [3:0] FS_SHR   = 4'hD;
  localparam logic [3:0] FS_SHL   = 4'hE;
  localparam logic [3:0] FS_ZERO  = 4'hF;

  localparam logic [3:0] BR_Z  = 4'h0;
  localparam logic [3:0] BR_N  = 4'h1;
  localparam logic [3:0] BR_ZF = 4'h2;
  localparam logic [3:0] BR_NF = 4'h3;

  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int FS_HI = 12;
  localparam int FS_LO = 9;
  localparam int DR_HI = 8;
  localparam int DR_LO = 6;
  localparam int SA_HI = 5;
  localparam int SA_LO = 3;
  localparam int SB_HI = 2;
  localparam int SB_LO = 0;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ALU) || (op == OP_ALUI);
  endfunction

endpackage

// File: rtl/mc_dp_alu.sv
// Combinational ALU: 16-entry function table producing a DW-bit result and
// {Z,N,C,V}. Arithmetic functions share one adder with a carry-in.
module mc_dp_alu
  import mc_dp_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [3:0]    i_fs,
  output logic [DW-1:0] o_result,
  output logic [3:0]    o_flags
);

  logic [DW-1:0] w_y;
  logic          w_cin;
  logic          w_arith;
  logic [DW:0]   w_sum;
  logic          w_c;
  logic          w_v;

  always_comb begin
    w_y      = '0;
    w_cin    = 1'b0;
    w_arith  = 1'b1;
    w_sum    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    o_result = '0;
    o_flags  = '0;

    // A is always the left adder operand; only the right operand and carry-in vary.
    case (i_fs)
      FS_INC:  begin w_y = '0;   w_cin = 1'b1; end
      FS_ADD:  begin w_y = i_b;  w_cin = 1'b0; end
      FS_ADDC: begin w_y = i_b;  w_cin = 1'b1; end
      FS_SUBB: begin w_y = ~i_b; w_cin = 1'b0; end
      FS_SUB:  begin w_y = ~i_b; w_cin = 1'b1; end
      FS_DEC:  begin w_y = '1;   w_cin = 1'b0; end
      default: w_arith = 1'b0;
    endcase

    w_sum = {1'b0, i_a} + {1'b0, w_y} + (DW+1)'(w_cin);

    if (w_arith) begin
      o_result = w_sum[DW-1:0];
      w_c      = w_sum[DW];
      w_v      = (i_a[DW-1] == w_y[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
    end else begin
      case (i_fs)
        FS_MOVA:  o_result = i_a;
        FS_MOVA2: o_result = i_a;
        FS_AND:   o_result = i_a & i_b;
        FS_OR:    o_result = i_a | i_b;
        FS_XOR:   o_result = i_a ^ i_b;
        FS_NOT:   o_result = ~i_a;
        FS_MOVB:  o_result = i_b;
        FS_SHR:   begin o_result = {1'b0, i_b[DW-1:1]}; w_c = i_b[0]; end
        FS_SHL:   begin o_result = {i_b[DW-2:0], 1'b0}; w_c = i_b[DW-1]; end
        FS_ZERO:  o_result = '0;
        default:  o_result = '0;
      endcase
    end

    o_flags[FLAG_Z] = (o_result == '0);
    o_flags[FLAG_N] = o_result[DW-1];
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle 16-bit-instruction datapath: IDLE/FETCH/EXEC/MEM/HALT control FSM,
// eight DW-bit registers, status flags, and req/ack instruction and data ports.
module mc_datapath
  import mc_dp_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] pc,
  output logic [3:0]    flags,
  output logic          halted,
  output logic          error
);

  // Handshake: a request stays high with address/data frozen until an ack is
  // sampled on a rising edge while req=1 (same-cycle ack allowed); that edge
  // completes the access. Acks seen while req=0 have no effect.

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_regs [8];
  logic [3:0]    r_flags;
  logic          r_error;

  logic [2:0]    w_op;
  logic [3:0]    w_fs;
  logic [2:0]    w_dr;
  logic [2:0]    w_sa;
  logic [2:0]    w_sb;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b_reg;
  logic [DW-1:0] w_alu_b;
  logic [DW-1:0] w_alu_res;
  logic [3:0]    w_alu_flags;
  logic [5:0]    w_br_off;
  logic [AW-1:0] w_br_ext;
  logic          w_br_taken;
  logic          w_fetch_done;
  logic          w_mem_done;
  logic [AW-1:0] w_pc_inc;

  assign w_op    = r_ir[OP_HI:OP_LO];
  assign w_fs    = r_ir[FS_HI:FS_LO];
  assign w_dr    = r_ir[DR_HI:DR_LO];
  assign w_sa    = r_ir[SA_HI:SA_LO];
  assign w_sb    = r_ir[SB_HI:SB_LO];
  assign w_a     = r_regs[w_sa];
  assign w_b_reg = r_regs[w_sb];
  assign w_alu_b = (w_op == OP_ALUI) ? DW'(w_sb) : w_b_reg;

  assign w_br_off = {w_dr, w_sb};
  assign w_br_ext = AW'($signed(w_br_off));
  assign w_pc_inc = r_pc + AW'(1);

  assign w_fetch_done = (r_state == ST_FETCH) && imem_ack;
  assign w_mem_done   = (r_state == ST_MEM) && dmem_ack;

  mc_dp_alu #(.DW(DW)) u_alu (
    .i_a      (w_a),
    .i_b      (w_alu_b),
    .i_fs     (w_fs),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

  always_comb begin
    w_br_taken = 1'b0;
    case (w_fs)
      BR_Z:    w_br_taken = (w_a == '0);
      BR_N:    w_br_taken = w_a[DW-1];
      BR_ZF:   w_br_taken = r_flags[FLAG_Z];
      BR_NF:   w_br_taken = r_flags[FLAG_N];
      default: w_br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (r_state)
      ST_IDLE:  if (run) w_next = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (w_op)
          OP_LD, OP_ST:    w_next = ST_MEM;
          OP_HALT, OP_ILL: w_next = ST_HALT;
          default:         w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_op == OP_ST);
        if (dmem_ack) w_next = ST_FETCH;
      end
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_flags <= '0;
      r_error <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      if (w_fetch_done) r_ir <= imem_rdata;
      if (r_state == ST_EXEC) begin
        case (w_op)
          OP_ALU, OP_ALUI: begin
            r_regs[w_dr] <= w_alu_res;
            r_flags      <= w_alu_flags;
            r_pc         <= w_pc_inc;
          end
          OP_BR:   r_pc    <= w_br_taken ? (r_pc + w_br_ext) : w_pc_inc;
          OP_JMP:  r_pc    <= w_a[AW-1:0];
          OP_ILL:  r_error <= 1'b1;
          default: ;
        endcase
      end
      // Loads and stores retire on the data ack edge, so pc only moves then.
      if (w_mem_done) begin
        if (w_op == OP_LD) r_regs[w_dr] <= dmem_rdata;
        r_pc <= w_pc_inc;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_addr  = w_a[AW-1:0];
  assign dmem_wdata = w_b_reg;
  assign flags      = r_flags;
  assign halted     = (r_state == ST_HALT);
  assign error      = r_error;

  logic w_unused;
  assign w_unused = is_alu_op(w_op);

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: table of ALU vectors plus hand-written sequences for
// memory stalls, branches, jumps, wrap, halt/illegal and reset mid-fetch.
module tb_mc_datapath;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic [AW-1:0] pc;
  logic [3:0]    flags;
  logic          halted;
  logic          error;

  mc_datapath #(.DW(DW), .AW(AW), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .flags(flags), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [AW-1:0]    exp_pc;
  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    logic          imm;
    logic [3:0]    fs;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic [3:0]    flg;
  } vec_t;
  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fetch(input logic [15:0] instr, input int dly);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("fetch_req", 32'(imem_req), 32'd1);
    if (imem_req !== 1'b1) return;
    check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("fetch_hold", 32'({imem_req, imem_addr}), 32'({1'b1, exp_pc}));
    end
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
  endtask

  task automatic mem(input int dly, input logic exp_we, input logic [AW-1:0] exp_addr,
                     input logic [DW-1:0] rd);
    int n = 0;
    logic [AW-1:0]    a0;
    logic [DW-1:0]    d0;
    logic [AW+DW-1:0] e;
    while (dmem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("mem_req", 32'(dmem_req), 32'd1);
    if (dmem_req !== 1'b1) return;
    a0 = dmem_addr;
    d0 = dmem_wdata;
    check("mem_we", 32'(dmem_we), 32'(exp_we));
    check("mem_addr", 32'(dmem_addr), 32'(exp_addr));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("mem_hold", 32'({dmem_req, dmem_we, dmem_addr, dmem_wdata}),
            32'({1'b1, exp_we, a0, d0}));
      check("mem_pc_hold", 32'(pc), 32'(exp_pc));
    end
    if (dmem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL store_unexpected: got %0h want none", {dmem_addr, dmem_wdata});
      end else begin
        e = exp_q.pop_front();
        check("store_data", 32'({dmem_addr, dmem_wdata}), 32'(e));
      end
    end
    dmem_rdata = rd;
    dmem_ack   = 1'b1;
    @(negedge clk);
    dmem_ack   = 1'b0;
    check("mem_req_drop", 32'(dmem_req), 32'd0);
  endtask

  task automatic ld(input logic [2:0] k, input logic [DW-1:0] val);
    fetch({3'b001, 4'h0, k, 3'd0, 3'd0}, 0);
    mem(0, 1'b0, 8'h00, val);
    exp_pc++;
  endtask

  task automatic st(input logic [2:0] sa, input logic [2:0] sb, input logic [AW-1:0] addr,
                    input logic [DW-1:0] data, input int dly);
    exp_q.push_back({addr, data});
    fetch({3'b010, 4'h0, 3'd0, sa, sb}, 0);
    mem(dly, 1'b1, addr, 16'h0000);
    exp_pc++;
  endtask

  task automatic alu(input string name, input logic [15:0] instr, input logic [3:0] f);
    fetch(instr, 0);
    @(negedge clk);
    exp_pc++;
    check({name, "_flags"}, 32'(flags), 32'(f));
    check({name, "_pc"}, 32'(pc), 32'(exp_pc));
  endtask

  task automatic ctl(input string name, input logic [15:0] instr, input logic [AW-1:0] new_pc);
    fetch(instr, 0);
    @(negedge clk);
    exp_pc = new_pc;
    check(name, 32'(pc), 32'(exp_pc));
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    summary();
    $finish;
  end

  initial begin
    logic [15:0] ins;

    // imm, fs, A, B (or imm), result, {Z,N,C,V}
    vecs[0]  = '{1'b0, 4'h2, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
    vecs[1]  = '{1'b0, 4'h5, 16'h0007, 16'h0007, 16'h0000, 4'b1010};
    vecs[2]  = '{1'b0, 4'h2, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
    vecs[3]  = '{1'b0, 4'h5, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100};
    vecs[4]  = '{1'b0, 4'h1, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101};
    vecs[5]  = '{1'b0, 4'h6, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100};
    vecs[6]  = '{1'b0, 4'h6, 16'h8000, 16'h0000, 16'h7FFF, 4'b0011};
    vecs[7]  = '{1'b0, 4'h3, 16'h0010, 16'h0020, 16'h0031, 4'b0000};
    vecs[8]  = '{1'b0, 4'h4, 16'h0005, 16'h0003, 16'h0001, 4'b0010};
    vecs[9]  = '{1'b0, 4'h8, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100};
    vecs[10] = '{1'b0, 4'h9, 16'h00F0, 16'h000F, 16'h00FF, 4'b0000};
    vecs[11] = '{1'b0, 4'hA, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000};
    vecs[12] = '{1'b0, 4'hB, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100};
    vecs[13] = '{1'b0, 4'hC, 16'h0000, 16'h8001, 16'h8001, 4'b0100};
    vecs[14] = '{1'b0, 4'hD, 16'h0000, 16'h8001, 16'h4000, 4'b0010};
    vecs[15] = '{1'b0, 4'hE, 16'h0000, 16'h8001, 16'h0002, 4'b0010};
    vecs[16] = '{1'b0, 4'hF, 16'h1234, 16'h5678, 16'h0000, 4'b1000};
    vecs[17] = '{1'b0, 4'h0, 16'h8000, 16'h0001, 16'h8000, 4'b0100};
    vecs[18] = '{1'b0, 4'h7, 16'h0000, 16'h0001, 16'h0000, 4'b1000};
    vecs[19] = '{1'b1, 4'h2, 16'h0005, 16'h0003, 16'h0008, 4'b0000};
    vecs[20] = '{1'b1, 4'h5, 16'h0007, 16'h0007, 16'h0000, 4'b1010};
    vecs[21] = '{1'b1, 4'hC, 16'h9999, 16'h0007, 16'h0007, 4'b0000};

    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_status", 32'({halted, error}), 32'h0);
    check("rst_reqs", 32'({imem_req, dmem_req, dmem_we}), 32'h0);
    @(negedge clk);
    check("idle_no_run", 32'(imem_req), 32'd0);
    run = 1'b1;
    exp_pc = 8'h00;

    alu("imm_r2", {3'b100, 4'h2, 3'd2, 3'd0, 3'd5}, 4'b0000);
    alu("imm_r3", {3'b100, 4'h2, 3'd3, 3'd0, 3'd3}, 4'b0000);
    alu("add_0453", 16'h0453, 4'b0000);
    st(3'd0, 3'd1, 8'h00, 16'h0008, 0);

    for (int i = 0; i < 22; i++) begin
      ld(3'd1, vecs[i].a);
      ld(3'd2, vecs[i].b);
      ins = {(vecs[i].imm ? 3'b100 : 3'b000), vecs[i].fs, 3'd3, 3'd1,
             (vecs[i].imm ? vecs[i].b[2:0] : 3'd2)};
      alu($sformatf("vec%0d", i), ins, vecs[i].flg);
      st(3'd0, 3'd3, 8'h00, vecs[i].res, 0);
    end

    ld(3'd2, 16'h1234);
    alu("imm_r1", {3'b100, 4'h2, 3'd1, 3'd0, 3'd4}, 4'b0000);
    st(3'd1, 3'd2, 8'h04, 16'h1234, 3);

    ld(3'd5, 16'h0000);
    ld(3'd4, 16'h000A);
    ctl("jmp_10", {3'b111, 4'h0, 3'd0, 3'd4, 3'd0}, 8'h0A);
    ctl("bz_taken", {3'b110, 4'h0, 3'b111, 3'd5, 3'b110}, 8'h08);
    ld(3'd5, 16'h0001);
    ctl("jmp_10b", {3'b111, 4'h0, 3'd0, 3'd4, 3'd0}, 8'h0A);
    ctl("bz_not_taken", {3'b110, 4'h0, 3'b111, 3'd5, 3'b110}, 8'h0B);

    ld(3'd6, 16'h01FF);
    ctl("jmp_trunc", {3'b111, 4'h0, 3'd0, 3'd6, 3'd0}, 8'hFF);
    alu("pc_wrap", {3'b100, 4'h2, 3'd7, 3'd0, 3'd1}, 4'b0000);
    alu("after_wrap", {3'b100, 4'h2, 3'd7, 3'd0, 3'd2}, 4'b0000);

    // Reset while a fetch at pc=1 is outstanding, then a stray ack with req low.
    @(negedge clk);
    check("pend_req", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h01}));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req", 32'(imem_req), 32'd0);
    check("rst_mid_pc", 32'(pc), 32'h00);
    check("rst_mid_flags", 32'(flags), 32'h0);
    rst = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    exp_pc = 8'h00;
    check("refetch", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h00}));
    st(3'd0, 3'd3, 8'h00, 16'h0000, 0);

    fetch(16'hA000, 0);
    @(negedge clk);
    check("ill_status", 32'({halted, error}), 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ill_no_fetch", 32'(imem_req), 32'd0);
    end

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_clear", 32'({halted, error}), 32'h0);
    exp_pc = 8'h00;
    fetch(16'h6000, 2);
    @(negedge clk);
    check("halt_status", 32'({halted, error}), 32'h2);
    check("halt_pc", 32'(pc), 32'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_stay", 32'({imem_req, halted}), 32'h1);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
